// File: rtl/data_memory_slave_pkg.sv
// Shared types and constants for the data-memory endpoint.
//   state_t       : request FSM states
//   LATENCY_MIN/MAX: legal range of the access latency parameter
//   LAT_CNT_BITS  : width of the latency down-counter (covers LATENCY_MAX)
package data_memory_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RESPOND,
    DRAIN
  } state_t;

  localparam int LATENCY_MIN  = 1;
  localparam int LATENCY_MAX  = 15;
  localparam int LAT_CNT_BITS = 4;

endpackage

// File: rtl/data_memory_slave_mem_array.sv
// Full-depth single-clock storage with two write ports and a combinational
// read port.
//   gpu_we/gpu_addr/gpu_data    : gpu commit port, wins on address conflict
//   host_we/host_addr/host_data : host preload port
//   rd_addr/rd_data             : asynchronous read
// The array has no reset so preloaded contents survive a reset.
module data_memory_slave_mem_array #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 gpu_we,
  input  logic [ADDR_BITS-1:0] gpu_addr,
  input  logic [DATA_BITS-1:0] gpu_data,
  input  logic                 host_we,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic [DATA_BITS-1:0] host_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];

  logic host_blocked;
  assign host_blocked = gpu_we && (gpu_addr == host_addr);

  always_ff @(posedge clk) begin
    if (host_we && !host_blocked) mem_q[host_addr] <= host_data;
    if (gpu_we)                   mem_q[gpu_addr]  <= gpu_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/data_memory_slave.sv
// Data-memory endpoint downstream of the gpu top level.
// Serves one read or write request at a time with a fixed LATENCY (1..15):
// a valid first sampled in cycle 0 gets its ready pulse in cycle LATENCY.
//   clk, reset                       : clock, synchronous active-high reset
//   mem_read_valid/address           : read request (held until ready)
//   mem_read_ready/data              : one-cycle ready pulse, data held
//   mem_write_valid/address/data     : write request (held until ready)
//   mem_write_ready                  : one-cycle commit pulse
//   host_write_enable/address/data   : preload port, writes in any state
//   host_collision                   : sticky, host write lost to gpu commit
//   read_count/write_count           : saturating completed-access counters
module data_memory_slave
  import data_memory_slave_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_BITS  = 8,
  parameter int LATENCY    = 2,
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_valid,
  input  logic [ADDR_BITS-1:0]  mem_read_address,
  output logic                  mem_read_ready,
  output logic [DATA_BITS-1:0]  mem_read_data,
  input  logic                  mem_write_valid,
  input  logic [ADDR_BITS-1:0]  mem_write_address,
  input  logic [DATA_BITS-1:0]  mem_write_data,
  output logic                  mem_write_ready,
  input  logic                  host_write_enable,
  input  logic [ADDR_BITS-1:0]  host_address,
  input  logic [DATA_BITS-1:0]  host_data,
  output logic                  host_collision,
  output logic [COUNT_BITS-1:0] read_count,
  output logic [COUNT_BITS-1:0] write_count
);

  localparam logic [LAT_CNT_BITS-1:0] LAT_INIT = LAT_CNT_BITS'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [LAT_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic                    rd_ready_q, rd_ready_d;
  logic                    wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]    rd_data_q, rd_data_d;
  logic                    coll_q, coll_d;
  logic [COUNT_BITS-1:0]   rd_cnt_q, rd_cnt_d;
  logic [COUNT_BITS-1:0]   wr_cnt_q, wr_cnt_d;

  // Access side of the array: the latched request while waiting, or the
  // live inputs when LATENCY==1 commits straight out of IDLE.
  logic                 commit_rd, commit_wr, gpu_we;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [DATA_BITS-1:0] acc_wdata;
  logic [DATA_BITS-1:0] arr_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    rd_ready_d = 1'b0;
    wr_ready_d = 1'b0;
    rd_data_d  = rd_data_q;
    commit_rd  = 1'b0;
    commit_wr  = 1'b0;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;

    case (state_q)
      IDLE: begin
        if (mem_write_valid) begin
          addr_d    = mem_write_address;
          wdata_d   = mem_write_data;
          is_wr_d   = 1'b1;
          cnt_d     = LAT_INIT;
          acc_addr  = mem_write_address;
          acc_wdata = mem_write_data;
          if (LATENCY == 1) commit_wr = 1'b1;
          else              state_d   = WRITE_WAIT;
        end else if (mem_read_valid) begin
          addr_d   = mem_read_address;
          is_wr_d  = 1'b0;
          cnt_d    = LAT_INIT;
          acc_addr = mem_read_address;
          if (LATENCY == 1) commit_rd = 1'b1;
          else              state_d   = READ_WAIT;
        end
      end
      // Commit on the edge where the counter reaches 0 so ready lands in
      // cycle LATENCY.
      READ_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_BITS'(1)) commit_rd = 1'b1;
      end
      WRITE_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LAT_CNT_BITS'(1)) commit_wr = 1'b1;
      end
      RESPOND: state_d = DRAIN;
      // Hold off until the served valid drops so it is not served twice.
      DRAIN: begin
        if (is_wr_q ? !mem_write_valid : !mem_read_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (commit_rd) begin
      rd_data_d  = arr_rdata;
      rd_ready_d = 1'b1;
      state_d    = RESPOND;
    end
    if (commit_wr) begin
      wr_ready_d = 1'b1;
      state_d    = RESPOND;
    end
  end

  // A commit on a reset edge is abandoned, so the array write is gated too.
  assign gpu_we = commit_wr && !reset;

  always_comb begin
    coll_d   = coll_q | (host_write_enable && gpu_we && (host_address == acc_addr));
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_ready_q && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + COUNT_BITS'(1);
    if (wr_ready_q && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + COUNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_wr_q    <= 1'b0;
      rd_ready_q <= 1'b0;
      wr_ready_q <= 1'b0;
      rd_data_q  <= '0;
      coll_q     <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q  <= rd_data_d;
      coll_q     <= coll_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  data_memory_slave_mem_array #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_mem_array (
    .clk      (clk),
    .gpu_we   (gpu_we),
    .gpu_addr (acc_addr),
    .gpu_data (acc_wdata),
    .host_we  (host_write_enable),
    .host_addr(host_address),
    .host_data(host_data),
    .rd_addr  (acc_addr),
    .rd_data  (arr_rdata)
  );

  assign mem_read_ready  = rd_ready_q;
  assign mem_read_data   = rd_data_q;
  assign mem_write_ready = wr_ready_q;
  assign host_collision  = coll_q;
  assign read_count      = rd_cnt_q;
  assign write_count     = wr_cnt_q;

endmodule

// File: tb/tb_data_memory_slave.sv
module tb_data_memory_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [7:0]  mem_read_data;
  logic        mem_write_valid;
  logic [7:0]  mem_write_address;
  logic [7:0]  mem_write_data;
  logic        mem_write_ready;
  logic        host_write_enable;
  logic [7:0]  host_address;
  logic [7:0]  host_data;
  logic        host_collision;
  logic [15:0] read_count;
  logic [15:0] write_count;

  // Second instance shares all inputs; only its narrow counters are checked.
  logic        s_read_ready, s_write_ready, s_collision;
  logic [7:0]  s_read_data;
  logic [1:0]  s_read_count, s_write_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_memory_slave #(.ADDR_BITS(8), .DATA_BITS(8), .LATENCY(2), .COUNT_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .host_write_enable(host_write_enable), .host_address(host_address),
    .host_data(host_data), .host_collision(host_collision),
    .read_count(read_count), .write_count(write_count)
  );

  data_memory_slave #(.ADDR_BITS(8), .DATA_BITS(8), .LATENCY(2), .COUNT_BITS(2)) dut_sat (
    .clk(clk), .reset(reset),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(s_read_ready), .mem_read_data(s_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(s_write_ready),
    .host_write_enable(host_write_enable), .host_address(host_address),
    .host_data(host_data), .host_collision(s_collision),
    .read_count(s_read_count), .write_count(s_write_count)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_read_valid = 1'b0;  mem_read_address = '0;
    mem_write_valid = 1'b0; mem_write_address = '0; mem_write_data = '0;
    host_write_enable = 1'b0; host_address = '0; host_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_write_enable = 1'b1; host_address = a; host_data = d;
    tick();
    host_write_enable = 1'b0;
  endtask

  // Drivers only: report whether ready arrived within the bound.
  task automatic gpu_read(input logic [7:0] a, output bit ok, output logic [7:0] d);
    ok = 1'b0; d = 'x;
    mem_read_valid = 1'b1; mem_read_address = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (mem_read_ready === 1'b1) begin ok = 1'b1; d = mem_read_data; end
    end
    mem_read_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic gpu_write(input logic [7:0] a, input logic [7:0] d, output bit ok);
    ok = 1'b0;
    mem_write_valid = 1'b1; mem_write_address = a; mem_write_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (mem_write_ready === 1'b1) ok = 1'b1;
    end
    mem_write_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({mem_read_ready, mem_write_ready, host_collision} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {mem_read_ready, mem_write_ready, host_collision});
    end
    n_vec++;
    if (mem_read_data !== 8'h00 || read_count !== 16'd0 || write_count !== 16'd0) begin
      n_err++; $display("FAIL reset_regs: data %h rc %0d wc %0d want 0 0 0", mem_read_data, read_count, write_count);
    end
  endtask

  task automatic test_read_latency();
    do_reset();
    host_wr(8'h10, 8'h2A);
    mem_read_valid = 1'b1; mem_read_address = 8'h10;   // cycle 0
    n_vec++;
    if (mem_read_ready !== 1'b0) begin n_err++; $display("FAIL lat_c0: ready %b want 0", mem_read_ready); end
    tick();                                            // cycle 1
    n_vec++;
    if (mem_read_ready !== 1'b0) begin n_err++; $display("FAIL lat_c1: ready %b want 0", mem_read_ready); end
    tick();                                            // cycle 2
    n_vec++;
    if (mem_read_ready !== 1'b1 || mem_read_data !== 8'h2A) begin
      n_err++; $display("FAIL lat_c2: ready %b data %h want 1 2a", mem_read_ready, mem_read_data);
    end
    tick();                                            // cycle 3, DRAIN
    n_vec++;
    if (mem_read_ready !== 1'b0) begin n_err++; $display("FAIL lat_c3: ready %b want 0", mem_read_ready); end
    mem_read_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if (read_count !== 16'd1) begin n_err++; $display("FAIL lat_rcount: got %0d want 1", read_count); end
  endtask

  task automatic test_write_read();
    bit ok; logic [7:0] d;
    do_reset();
    gpu_write(8'h03, 8'h55, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wr_ready: got timeout want pulse"); end
    gpu_read(8'h03, ok, d);
    n_vec++;
    if (!ok || d !== 8'h55) begin n_err++; $display("FAIL wr_rd_data: ok %b data %h want 1 55", ok, d); end
    n_vec++;
    if (write_count !== 16'd1 || read_count !== 16'd1) begin
      n_err++; $display("FAIL wr_rd_counts: wc %0d rc %0d want 1 1", write_count, read_count);
    end
  endtask

  task automatic test_priority();
    bit wok, rok, early; logic [7:0] d;
    do_reset();
    wok = 0; rok = 0; early = 0; d = 'x;
    mem_write_valid = 1'b1; mem_write_address = 8'h04; mem_write_data = 8'h77;
    mem_read_valid  = 1'b1; mem_read_address  = 8'h04;
    for (int i = 0; i < 20 && !wok; i++) begin
      tick();
      if (mem_read_ready === 1'b1) early = 1'b1;
      if (mem_write_ready === 1'b1) wok = 1'b1;
    end
    mem_write_valid = 1'b0;
    n_vec++;
    if (!wok || early) begin n_err++; $display("FAIL prio_write_first: wok %b early_read %b want 1 0", wok, early); end
    for (int i = 0; i < 20 && !rok; i++) begin
      tick();
      if (mem_read_ready === 1'b1) begin rok = 1'b1; d = mem_read_data; end
    end
    mem_read_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if (!rok || d !== 8'h77) begin n_err++; $display("FAIL prio_read_data: ok %b data %h want 1 77", rok, d); end
    n_vec++;
    if (write_count !== 16'd1 || read_count !== 16'd1) begin
      n_err++; $display("FAIL prio_counts: wc %0d rc %0d want 1 1", write_count, read_count);
    end
  endtask

  task automatic test_hold_valid();
    bit ok; int pulses;
    do_reset();
    ok = 0; pulses = 0;
    mem_read_valid = 1'b1; mem_read_address = 8'h10;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (mem_read_ready === 1'b1) ok = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_read_ready !== 1'b0) pulses++;
    end
    mem_read_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if (!ok || pulses != 0) begin n_err++; $display("FAIL hold_single_pulse: ok %b extra %0d want 1 0", ok, pulses); end
    n_vec++;
    if (read_count !== 16'd1) begin n_err++; $display("FAIL hold_rcount: got %0d want 1", read_count); end
  endtask

  task automatic test_host();
    bit ok; logic [7:0] d;
    do_reset();
    // Host write during READ_WAIT is visible to the read.
    host_wr(8'h20, 8'h01);
    mem_read_valid = 1'b1; mem_read_address = 8'h20;
    host_write_enable = 1'b1; host_address = 8'h20; host_data = 8'h5C;
    tick();
    host_write_enable = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_read_ready === 1'b1) begin ok = 1'b1; d = mem_read_data; end
      else tick();
    end
    mem_read_valid = 1'b0;
    tick(); tick();
    n_vec++;
    if (!ok || d !== 8'h5C) begin n_err++; $display("FAIL host_during_wait: ok %b data %h want 1 5c", ok, d); end
    n_vec++;
    if (host_collision !== 1'b0) begin n_err++; $display("FAIL host_no_coll: got %b want 0", host_collision); end
    // Host write on the gpu commit edge, same address.
    mem_write_valid = 1'b1; mem_write_address = 8'h08; mem_write_data = 8'h99;  // cycle 0
    tick();                                                                    // cycle 1
    host_write_enable = 1'b1; host_address = 8'h08; host_data = 8'h11;
    tick();                                                                    // cycle 2
    host_write_enable = 1'b0;
    n_vec++;
    if (mem_write_ready !== 1'b1 || host_collision !== 1'b1) begin
      n_err++; $display("FAIL coll_set: ready %b coll %b want 1 1", mem_write_ready, host_collision);
    end
    mem_write_valid = 1'b0;
    tick(); tick();
    gpu_read(8'h08, ok, d);
    n_vec++;
    if (!ok || d !== 8'h99) begin n_err++; $display("FAIL coll_data: ok %b data %h want 1 99", ok, d); end
    n_vec++;
    if (host_collision !== 1'b1) begin n_err++; $display("FAIL coll_sticky: got %b want 1", host_collision); end
  endtask

  task automatic test_reset_midop();
    bit ok, seen; logic [7:0] d;
    // Previous test left read data 0x99 and collision set.
    mem_read_valid = 1'b1; mem_read_address = 8'h10;   // cycle 0
    tick();                                            // cycle 1, READ_WAIT
    reset = 1'b1; mem_read_valid = 1'b0;
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_read_ready !== 1'b0) seen = 1'b1;
      tick();
    end
    n_vec++;
    if (seen) begin n_err++; $display("FAIL midrst_pulse: got pulse want none"); end
    n_vec++;
    if (read_count !== 16'd0 || write_count !== 16'd0 || host_collision !== 1'b0 || mem_read_data !== 8'h00) begin
      n_err++; $display("FAIL midrst_state: rc %0d wc %0d coll %b data %h want 0 0 0 00",
                        read_count, write_count, host_collision, mem_read_data);
    end
    gpu_read(8'h10, ok, d);
    n_vec++;
    if (!ok || d !== 8'h2A) begin n_err++; $display("FAIL midrst_array: ok %b data %h want 1 2a", ok, d); end
  endtask

  task automatic test_saturate();
    bit ok; logic [7:0] d;
    do_reset();
    for (int i = 0; i < 5; i++) gpu_read(8'h03, ok, d);
    n_vec++;
    if (s_read_count !== 2'd3) begin n_err++; $display("FAIL sat_count2: got %0d want 3", s_read_count); end
    n_vec++;
    if (read_count !== 16'd5) begin n_err++; $display("FAIL sat_count16: got %0d want 5", read_count); end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write_read();
    test_priority();
    test_hold_valid();
    test_host();
    test_reset_midop();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
